// File: rtl/cnn_pkg.sv
// Shared CNN datapath helpers: default sample width, signed range bounds and signed max.
package cnn_pkg;

    localparam int CNN_DATA_BITS = 32;
    localparam int CNN_MAX_BITS  = 64;

    // Largest and smallest signed value representable in 'bits' bits, held at CNN_MAX_BITS.
    function automatic logic signed [CNN_MAX_BITS-1:0] smax_of(input int unsigned bits);
        return (64'sd1 <<< (bits - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [CNN_MAX_BITS-1:0] smin_of(input int unsigned bits);
        return -(64'sd1 <<< (bits - 1));
    endfunction

    function automatic logic signed [CNN_MAX_BITS-1:0] smax(
        input logic signed [CNN_MAX_BITS-1:0] a,
        input logic signed [CNN_MAX_BITS-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/chan_adder_sat.sv
// Combinational channel sum plus bias, reduced to DATA_BITS.
// CHAN_SUM_POOL_SATURATE_EN selects clamping; otherwise the wide sum wraps.
module chan_adder_sat
    import cnn_pkg::*;
#(
    parameter int DATA_BITS = CNN_DATA_BITS,
    parameter int CHANNELS  = 3
) (
    input  logic [CHANNELS*DATA_BITS-1:0] in_data,
    input  logic [DATA_BITS-1:0]          bias,
    output logic [DATA_BITS-1:0]          sum
);

    localparam int WIDE = DATA_BITS + $clog2(CHANNELS + 1);
    localparam int EXT  = WIDE - DATA_BITS;

    logic signed [WIDE-1:0] ext [CHANNELS];
    logic signed [WIDE-1:0] acc;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ext
        assign ext[k] = {{EXT{in_data[k*DATA_BITS + DATA_BITS-1]}},
                         in_data[k*DATA_BITS +: DATA_BITS]};
    end

    always_comb begin
        acc = {{EXT{bias[DATA_BITS-1]}}, bias};
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            acc = acc + ext[k];
        end
    end

`ifdef CHAN_SUM_POOL_SATURATE_EN
    localparam logic signed [WIDE-1:0] SAT_HI = WIDE'(smax_of(DATA_BITS));
    localparam logic signed [WIDE-1:0] SAT_LO = WIDE'(smin_of(DATA_BITS));

    always_comb begin
        if (acc > SAT_HI) begin
            sum = SAT_HI[DATA_BITS-1:0];
        end else if (acc < SAT_LO) begin
            sum = SAT_LO[DATA_BITS-1:0];
        end else begin
            sum = acc[DATA_BITS-1:0];
        end
    end
`else
    logic [EXT-1:0] unused_hi;

    always_comb begin
        sum       = acc[DATA_BITS-1:0];
        unused_hi = acc[WIDE-1:DATA_BITS];
    end
`endif

endmodule

// File: rtl/chan_sum_pool.sv
// Per-pixel channel sum + bias + ReLU followed by POOL_SIZE x POOL_SIZE max-pooling
// with a valid/ready stream on both sides. Optional clamp: CHAN_SUM_POOL_SATURATE_EN.
module chan_sum_pool
    import cnn_pkg::*;
#(
    parameter int DATA_BITS = CNN_DATA_BITS,
    parameter int CHANNELS  = 3,
    parameter int WIDTH     = 8,
    parameter int HEIGHT    = 8,
    parameter int POOL_SIZE = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CHANNELS*DATA_BITS-1:0] in_data,
    input  logic [DATA_BITS-1:0]          bias,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_BITS-1:0]          out_data,
    output logic                          out_last
);

    localparam int GROUPS = WIDTH / POOL_SIZE;
    localparam int PW     = $clog2(POOL_SIZE);
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [DATA_BITS-1:0] raw_sum;
    logic [DATA_BITS-1:0] pix;
    logic [DATA_BITS-1:0] gmax;
    logic [DATA_BITS-1:0] gcur;
    logic [DATA_BITS-1:0] lb_rd;
    logic [DATA_BITS-1:0] win;
    logic [DATA_BITS-1:0] line_buf [GROUPS];

    // Column x is carried as (group index gi, position within group px); row as y plus y%POOL_SIZE in py.
    logic [PW-1:0] px;
    logic [PW-1:0] py;
    logic [GW-1:0] gi;
    logic [YW-1:0] y;

    logic accept;
    logic grp_end;
    logic last_grp;
    logic last_row;
    logic win_row;

    function automatic logic [DATA_BITS-1:0] dmax(
        input logic [DATA_BITS-1:0] a,
        input logic [DATA_BITS-1:0] b
    );
        return DATA_BITS'(smax({{(CNN_MAX_BITS-DATA_BITS){a[DATA_BITS-1]}}, a},
                               {{(CNN_MAX_BITS-DATA_BITS){b[DATA_BITS-1]}}, b}));
    endfunction

    chan_adder_sat #(
        .DATA_BITS (DATA_BITS),
        .CHANNELS  (CHANNELS)
    ) u_adder (
        .in_data (in_data),
        .bias    (bias),
        .sum     (raw_sum)
    );

    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign pix      = raw_sum[DATA_BITS-1] ? '0 : raw_sum;
    assign gcur     = (px == '0) ? pix : dmax(gmax, pix);
    assign grp_end  = (px == PW'(POOL_SIZE - 1));
    assign last_grp = (gi == GW'(GROUPS - 1));
    assign last_row = (y == YW'(HEIGHT - 1));
    assign win_row  = (py == PW'(POOL_SIZE - 1));
    assign lb_rd    = line_buf[gi];
    // The first row of a window band writes the group max; later rows fold into it.
    assign win      = (py == '0) ? gcur : dmax(lb_rd, gcur);

    always_ff @(posedge clk) begin
        if (accept && grp_end) begin
            line_buf[gi] <= win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            px        <= '0;
            py        <= '0;
            gi        <= '0;
            y         <= '0;
            gmax      <= '0;
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                gmax <= gcur;
                if (grp_end) begin
                    px <= '0;
                    if (win_row) begin
                        out_data  <= win;
                        out_valid <= 1'b1;
                        out_last  <= last_grp && last_row;
                    end
                    if (last_grp) begin
                        gi <= '0;
                        py <= win_row ? '0 : py + 1'b1;
                        y  <= last_row ? '0 : y + 1'b1;
                    end else begin
                        gi <= gi + 1'b1;
                    end
                end else begin
                    px <= px + 1'b1;
                end
            end
        end
    end

endmodule
